// File: rtl/decode_stage.sv
//------------------------------------------------------------------------------
// decode_stage
//
// Instruction-decode stage of a 5-stage MIPS pipeline.
//
// Responsibilities:
//   - Presents rs/rt read addresses to the register file (combinational).
//   - Decodes the control word and extends the immediate.
//   - Latches all decoded fields into the ID/EX pipeline register.
//   - Detects load-use hazards (o_stall) and applies branch flushes from EX.
//
// Optional feature (macro WB_BYPASS_EN):
//   When WB_BYPASS_EN is defined, a same-cycle write-back to a register being
//   read in ID replaces the register file data latched into ID/EX.
//   When it is undefined, the i_wb_* ports are present but ignored.
//
// Ports:
//   clk, reset                  clock, asynchronous active-high reset
//   i_instruction, i_pc_plus4   instruction and PC+4 from IF/ID
//   i_valid                     IF/ID holds a real instruction
//   i_flush                     EX branch taken, squash ID
//   o_rs_addr, o_rt_addr        register file read addresses (combinational)
//   i_rs_data, i_rt_data        register file read data
//   i_wb_reg_write/addr/data    write-back port (used only for the bypass)
//   o_stall                     hold PC and IF/ID this cycle (combinational)
//   o_valid .. o_wr_addr        registered ID/EX pipeline register contents
//------------------------------------------------------------------------------
module decode_stage #(
    parameter int REG_ADDR_W = 5,
    parameter int DATA_W     = 32
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [DATA_W-1:0]     i_instruction,
    input  logic [DATA_W-1:0]     i_pc_plus4,
    input  logic                  i_valid,
    input  logic                  i_flush,
    output logic [REG_ADDR_W-1:0] o_rs_addr,
    output logic [REG_ADDR_W-1:0] o_rt_addr,
    input  logic [DATA_W-1:0]     i_rs_data,
    input  logic [DATA_W-1:0]     i_rt_data,
    input  logic                  i_wb_reg_write,
    input  logic [REG_ADDR_W-1:0] i_wb_addr,
    input  logic [DATA_W-1:0]     i_wb_data,
    output logic                  o_stall,
    output logic                  o_valid,
    output logic                  o_reg_write,
    output logic                  o_mem_read,
    output logic                  o_mem_write,
    output logic                  o_mem_to_reg,
    output logic                  o_alu_src,
    output logic                  o_branch,
    output logic [2:0]            o_alu_op,
    output logic [5:0]            o_funct,
    output logic [DATA_W-1:0]     o_rs_data,
    output logic [DATA_W-1:0]     o_rt_data,
    output logic [DATA_W-1:0]     o_imm_ext,
    output logic [DATA_W-1:0]     o_pc_plus4,
    output logic [REG_ADDR_W-1:0] o_rs,
    output logic [REG_ADDR_W-1:0] o_rt,
    output logic [REG_ADDR_W-1:0] o_wr_addr
);

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_ANDI  = 6'h0C;
    localparam logic [5:0] OP_ORI   = 6'h0D;
    localparam logic [5:0] OP_LUI   = 6'h0F;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;

    localparam logic [2:0] ALU_ADD   = 3'b000;
    localparam logic [2:0] ALU_SUB   = 3'b001;
    localparam logic [2:0] ALU_AND   = 3'b010;
    localparam logic [2:0] ALU_OR    = 3'b011;
    localparam logic [2:0] ALU_IMM   = 3'b100;
    localparam logic [2:0] ALU_FUNCT = 3'b101;

    typedef struct packed {
        logic                  valid;
        logic                  reg_write;
        logic                  mem_read;
        logic                  mem_write;
        logic                  mem_to_reg;
        logic                  alu_src;
        logic                  branch;
        logic [2:0]            alu_op;
        logic [5:0]            funct;
        logic [DATA_W-1:0]     rs_data;
        logic [DATA_W-1:0]     rt_data;
        logic [DATA_W-1:0]     imm_ext;
        logic [DATA_W-1:0]     pc_plus4;
        logic [REG_ADDR_W-1:0] rs;
        logic [REG_ADDR_W-1:0] rt;
        logic [REG_ADDR_W-1:0] wr_addr;
    } idex_t;

    logic [5:0]            opcode;
    logic [REG_ADDR_W-1:0] rs_field;
    logic [REG_ADDR_W-1:0] rt_field;
    logic [REG_ADDR_W-1:0] rd_field;
    logic [15:0]           imm_field;
    logic [DATA_W-1:0]     rs_val;
    logic [DATA_W-1:0]     rt_val;
    logic                  supported;
    logic                  is_rtype;
    logic                  uses_rs;
    logic                  uses_rt;
    logic                  hazard_rs;
    logic                  hazard_rt;
    logic                  load_bubble;
    idex_t                 dec;
    idex_t                 nxt;
    idex_t                 idex;

    assign opcode    = i_instruction[31:26];
    assign rs_field  = i_instruction[21 +: REG_ADDR_W];
    assign rt_field  = i_instruction[16 +: REG_ADDR_W];
    assign rd_field  = i_instruction[11 +: REG_ADDR_W];
    assign imm_field = i_instruction[15:0];

    assign o_rs_addr = rs_field;
    assign o_rt_addr = rt_field;

`ifdef WB_BYPASS_EN
    // A register file that writes on the clock edge returns the old value in
    // the same cycle WB writes it, so take the WB data directly.
    assign rs_val = (i_wb_reg_write && (i_wb_addr != '0) && (i_wb_addr == rs_field))
                    ? i_wb_data : i_rs_data;
    assign rt_val = (i_wb_reg_write && (i_wb_addr != '0) && (i_wb_addr == rt_field))
                    ? i_wb_data : i_rt_data;
`else
    logic unused_wb;
    assign unused_wb = ^{i_wb_reg_write, i_wb_addr, i_wb_data};
    assign rs_val    = i_rs_data;
    assign rt_val    = i_rt_data;
`endif

    // Main decoder: produces the full ID/EX word for the current instruction,
    // plus which source registers it actually reads for hazard detection.
    always_comb begin
        supported      = 1'b0;
        is_rtype       = 1'b0;
        uses_rs        = 1'b0;
        uses_rt        = 1'b0;
        dec            = '0;
        dec.funct      = i_instruction[5:0];
        dec.rs_data    = rs_val;
        dec.rt_data    = rt_val;
        dec.pc_plus4   = i_pc_plus4;
        dec.rs         = rs_field;
        dec.rt         = rt_field;
        dec.imm_ext    = {{(DATA_W-16){imm_field[15]}}, imm_field};

        case (opcode)
            OP_RTYPE: begin
                supported     = 1'b1;
                is_rtype      = 1'b1;
                uses_rs       = 1'b1;
                uses_rt       = 1'b1;
                dec.reg_write = 1'b1;
                dec.alu_op    = ALU_FUNCT;
            end
            OP_ADDI: begin
                supported     = 1'b1;
                uses_rs       = 1'b1;
                dec.reg_write = 1'b1;
                dec.alu_src   = 1'b1;
                dec.alu_op    = ALU_ADD;
            end
            OP_ANDI: begin
                supported     = 1'b1;
                uses_rs       = 1'b1;
                dec.reg_write = 1'b1;
                dec.alu_src   = 1'b1;
                dec.alu_op    = ALU_AND;
                dec.imm_ext   = {{(DATA_W-16){1'b0}}, imm_field};
            end
            OP_ORI: begin
                supported     = 1'b1;
                uses_rs       = 1'b1;
                dec.reg_write = 1'b1;
                dec.alu_src   = 1'b1;
                dec.alu_op    = ALU_OR;
                dec.imm_ext   = {{(DATA_W-16){1'b0}}, imm_field};
            end
            OP_LUI: begin
                supported     = 1'b1;
                dec.reg_write = 1'b1;
                dec.alu_src   = 1'b1;
                dec.alu_op    = ALU_IMM;
                dec.imm_ext   = {imm_field, {(DATA_W-16){1'b0}}};
            end
            OP_LW: begin
                supported      = 1'b1;
                uses_rs        = 1'b1;
                dec.reg_write  = 1'b1;
                dec.mem_read   = 1'b1;
                dec.mem_to_reg = 1'b1;
                dec.alu_src    = 1'b1;
                dec.alu_op     = ALU_ADD;
            end
            OP_SW: begin
                supported     = 1'b1;
                uses_rs       = 1'b1;
                uses_rt       = 1'b1;
                dec.mem_write = 1'b1;
                dec.alu_src   = 1'b1;
                dec.alu_op    = ALU_ADD;
            end
            OP_BEQ: begin
                supported  = 1'b1;
                uses_rs    = 1'b1;
                uses_rt    = 1'b1;
                dec.branch = 1'b1;
                dec.alu_op = ALU_SUB;
            end
            default: begin
                supported = 1'b0;
            end
        endcase

        dec.valid = supported;

        // Non-writers carry destination 0 so they can never match a hazard.
        if (dec.reg_write) begin
            dec.wr_addr = is_rtype ? rd_field : rt_field;
        end else begin
            dec.wr_addr = '0;
        end
    end

    // Only registers the current instruction really reads can cause a stall;
    // an I-type's rt field is its destination and must not match.
    assign hazard_rs = uses_rs && (idex.wr_addr == rs_field);
    assign hazard_rt = uses_rt && (idex.wr_addr == rt_field);

    assign o_stall = !reset && i_valid && !i_flush &&
                     idex.valid && idex.mem_read && (idex.wr_addr != '0) &&
                     (hazard_rs || hazard_rt);

    // A bubble is inserted for flush, stall, empty slot or unknown opcode.
    // Because the stall inserts a bubble, the re-decoded instruction next
    // cycle no longer sees a load in ID/EX, so each stall lasts one cycle.
    assign load_bubble = !i_valid || i_flush || o_stall || !supported;
    assign nxt         = load_bubble ? '0 : dec;

    // ID/EX pipeline register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            idex <= '0;
        end else begin
            idex <= nxt;
        end
    end

    assign o_valid      = idex.valid;
    assign o_reg_write  = idex.reg_write;
    assign o_mem_read   = idex.mem_read;
    assign o_mem_write  = idex.mem_write;
    assign o_mem_to_reg = idex.mem_to_reg;
    assign o_alu_src    = idex.alu_src;
    assign o_branch     = idex.branch;
    assign o_alu_op     = idex.alu_op;
    assign o_funct      = idex.funct;
    assign o_rs_data    = idex.rs_data;
    assign o_rt_data    = idex.rt_data;
    assign o_imm_ext    = idex.imm_ext;
    assign o_pc_plus4   = idex.pc_plus4;
    assign o_rs         = idex.rs;
    assign o_rt         = idex.rt;
    assign o_wr_addr    = idex.wr_addr;

endmodule

// File: tb/tb_decode_stage.sv
//------------------------------------------------------------------------------
// tb_decode_stage
//
// Directed scoreboard bench for decode_stage. Each stimulus pushes the
// hand-computed ID/EX word expected after the next clock edge; a separate
// monitor pops and compares after every rising edge. o_stall is checked
// combinationally right after the inputs are driven.
//------------------------------------------------------------------------------
module tb_decode_stage;

    typedef struct packed {
        logic [6:0]  ctrl;     // {valid, reg_write, mem_read, mem_write, mem_to_reg, alu_src, branch}
        logic [2:0]  alu_op;
        logic [5:0]  funct;
        logic [31:0] rs_data;
        logic [31:0] rt_data;
        logic [31:0] imm_ext;
        logic [31:0] pc_plus4;
        logic [4:0]  rs;
        logic [4:0]  rt;
        logic [4:0]  wr_addr;
    } idex_t;

    logic        clk;
    logic        reset;
    logic [31:0] i_instruction;
    logic [31:0] i_pc_plus4;
    logic        i_valid;
    logic        i_flush;
    logic [4:0]  o_rs_addr;
    logic [4:0]  o_rt_addr;
    logic [31:0] i_rs_data;
    logic [31:0] i_rt_data;
    logic        i_wb_reg_write;
    logic [4:0]  i_wb_addr;
    logic [31:0] i_wb_data;
    logic        o_stall;
    logic        o_valid;
    logic        o_reg_write;
    logic        o_mem_read;
    logic        o_mem_write;
    logic        o_mem_to_reg;
    logic        o_alu_src;
    logic        o_branch;
    logic [2:0]  o_alu_op;
    logic [5:0]  o_funct;
    logic [31:0] o_rs_data;
    logic [31:0] o_rt_data;
    logic [31:0] o_imm_ext;
    logic [31:0] o_pc_plus4;
    logic [4:0]  o_rs;
    logic [4:0]  o_rt;
    logic [4:0]  o_wr_addr;

    int    total;
    int    bad;
    idex_t exp_q[$];
    string name_q[$];
    idex_t bubble;

    decode_stage #(.REG_ADDR_W(5), .DATA_W(32)) dut (
        .clk(clk),
        .reset(reset),
        .i_instruction(i_instruction),
        .i_pc_plus4(i_pc_plus4),
        .i_valid(i_valid),
        .i_flush(i_flush),
        .o_rs_addr(o_rs_addr),
        .o_rt_addr(o_rt_addr),
        .i_rs_data(i_rs_data),
        .i_rt_data(i_rt_data),
        .i_wb_reg_write(i_wb_reg_write),
        .i_wb_addr(i_wb_addr),
        .i_wb_data(i_wb_data),
        .o_stall(o_stall),
        .o_valid(o_valid),
        .o_reg_write(o_reg_write),
        .o_mem_read(o_mem_read),
        .o_mem_write(o_mem_write),
        .o_mem_to_reg(o_mem_to_reg),
        .o_alu_src(o_alu_src),
        .o_branch(o_branch),
        .o_alu_op(o_alu_op),
        .o_funct(o_funct),
        .o_rs_data(o_rs_data),
        .o_rt_data(o_rt_data),
        .o_imm_ext(o_imm_ext),
        .o_pc_plus4(o_pc_plus4),
        .o_rs(o_rs),
        .o_rt(o_rt),
        .o_wr_addr(o_wr_addr)
    );

    // Free-running clock, period 10.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic idex_t mk(input logic [6:0] ctrl, input logic [2:0] alu_op,
                                 input logic [5:0] funct, input logic [31:0] rs_data,
                                 input logic [31:0] rt_data, input logic [31:0] imm_ext,
                                 input logic [31:0] pc_plus4, input logic [4:0] rs,
                                 input logic [4:0] rt, input logic [4:0] wr_addr);
        idex_t r;
        r.ctrl     = ctrl;
        r.alu_op   = alu_op;
        r.funct    = funct;
        r.rs_data  = rs_data;
        r.rt_data  = rt_data;
        r.imm_ext  = imm_ext;
        r.pc_plus4 = pc_plus4;
        r.rs       = rs;
        r.rt       = rt;
        r.wr_addr  = wr_addr;
        return r;
    endfunction

    function automatic idex_t sample_dut();
        return mk({o_valid, o_reg_write, o_mem_read, o_mem_write, o_mem_to_reg, o_alu_src, o_branch},
                  o_alu_op, o_funct, o_rs_data, o_rt_data, o_imm_ext, o_pc_plus4,
                  o_rs, o_rt, o_wr_addr);
    endfunction

    task automatic checkOutput(input string name, input logic [191:0] act, input logic [191:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Drive one ID cycle at the falling edge, check the combinational stall,
    // then queue the ID/EX word expected after the next rising edge.
    task automatic applyStimulus(input string name, input logic [31:0] instr,
                                 input logic [31:0] pc, input logic valid, input logic flush,
                                 input logic [31:0] rs_data, input logic [31:0] rt_data,
                                 input logic wb_we, input logic [4:0] wb_addr,
                                 input logic [31:0] wb_data, input logic exp_stall,
                                 input idex_t exp);
        @(negedge clk);
        i_instruction  = instr;
        i_pc_plus4     = pc;
        i_valid        = valid;
        i_flush        = flush;
        i_rs_data      = rs_data;
        i_rt_data      = rt_data;
        i_wb_reg_write = wb_we;
        i_wb_addr      = wb_addr;
        i_wb_data      = wb_data;
        #1;
        checkOutput({name, "_stall"}, {191'd0, o_stall}, {191'd0, exp_stall});
        exp_q.push_back(exp);
        name_q.push_back(name);
    endtask

    // Monitor: ID/EX presents a new word after every rising edge.
    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) begin
                checkOutput(name_q.pop_front(), {33'd0, sample_dut()}, {33'd0, exp_q.pop_front()});
            end
        end
    end

    initial begin
        logic [31:0] bypass_exp;
        bubble         = '0;
        total          = 0;
        bad            = 0;
        reset          = 1'b1;
        i_instruction  = 32'h0;
        i_pc_plus4     = 32'h0;
        i_valid        = 1'b0;
        i_flush        = 1'b0;
        i_rs_data      = 32'h0;
        i_rt_data      = 32'h0;
        i_wb_reg_write = 1'b0;
        i_wb_addr      = 5'd0;
        i_wb_data      = 32'h0;
`ifdef WB_BYPASS_EN
        bypass_exp = 32'hDEADBEEF;
`else
        bypass_exp = 32'h0;
`endif

        #2;
        checkOutput("reset_state", {33'd0, sample_dut()}, 192'd0);
        checkOutput("reset_stall", {191'd0, o_stall}, 192'd0);
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;

        $display("[TB] decode of basic I-types");
        applyStimulus("addi", 32'h2109FFFC, 32'h100, 1, 0, 32'h10, 32'h22, 0, 5'd0, 32'h0, 0,
                      mk(7'b1100010, 3'b000, 6'h3C, 32'h10, 32'h22, 32'hFFFFFFFC, 32'h100, 5'd8, 5'd9, 5'd9));
        applyStimulus("ori", 32'h35098000, 32'h104, 1, 0, 32'h10, 32'h22, 0, 5'd0, 32'h0, 0,
                      mk(7'b1100010, 3'b011, 6'h00, 32'h10, 32'h22, 32'h00008000, 32'h104, 5'd8, 5'd9, 5'd9));
        applyStimulus("lui", 32'h3C091234, 32'h108, 1, 0, 32'h10, 32'h22, 0, 5'd0, 32'h0, 0,
                      mk(7'b1100010, 3'b100, 6'h34, 32'h10, 32'h22, 32'h12340000, 32'h108, 5'd0, 5'd9, 5'd9));
        applyStimulus("andi", 32'h3109FFFF, 32'h10C, 1, 0, 32'h10, 32'h22, 0, 5'd0, 32'h0, 0,
                      mk(7'b1100010, 3'b010, 6'h3F, 32'h10, 32'h22, 32'h0000FFFF, 32'h10C, 5'd8, 5'd9, 5'd9));
        applyStimulus("beq", 32'h1109FFFF, 32'h110, 1, 0, 32'h10, 32'h22, 0, 5'd0, 32'h0, 0,
                      mk(7'b1000001, 3'b001, 6'h3F, 32'h10, 32'h22, 32'hFFFFFFFF, 32'h110, 5'd8, 5'd9, 5'd0));
        applyStimulus("sw", 32'hAD090004, 32'h114, 1, 0, 32'h10, 32'h22, 0, 5'd0, 32'h0, 0,
                      mk(7'b1001010, 3'b000, 6'h04, 32'h10, 32'h22, 32'h00000004, 32'h114, 5'd8, 5'd9, 5'd0));

        $display("[TB] load-use hazard");
        applyStimulus("lw", 32'h8D090000, 32'h118, 1, 0, 32'h10, 32'h22, 0, 5'd0, 32'h0, 0,
                      mk(7'b1110110, 3'b000, 6'h00, 32'h10, 32'h22, 32'h0, 32'h118, 5'd8, 5'd9, 5'd9));
        applyStimulus("add_stalled", 32'h01285020, 32'h11C, 1, 0, 32'h33, 32'h10, 0, 5'd0, 32'h0, 1, bubble);
        applyStimulus("add_redecode", 32'h01285020, 32'h11C, 1, 0, 32'h33, 32'h10, 0, 5'd0, 32'h0, 0,
                      mk(7'b1100000, 3'b101, 6'h20, 32'h33, 32'h10, 32'h00005020, 32'h11C, 5'd9, 5'd8, 5'd10));
        applyStimulus("lw_r0", 32'h8D000000, 32'h120, 1, 0, 32'h10, 32'h0, 0, 5'd0, 32'h0, 0,
                      mk(7'b1110110, 3'b000, 6'h00, 32'h10, 32'h0, 32'h0, 32'h120, 5'd8, 5'd0, 5'd0));
        applyStimulus("add_r0", 32'h00005020, 32'h124, 1, 0, 32'h0, 32'h0, 0, 5'd0, 32'h0, 0,
                      mk(7'b1100000, 3'b101, 6'h20, 32'h0, 32'h0, 32'h00005020, 32'h124, 5'd0, 5'd0, 5'd10));
        applyStimulus("lw2", 32'h8D090000, 32'h128, 1, 0, 32'h10, 32'h22, 0, 5'd0, 32'h0, 0,
                      mk(7'b1110110, 3'b000, 6'h00, 32'h10, 32'h22, 32'h0, 32'h128, 5'd8, 5'd9, 5'd9));
        applyStimulus("addi_rt_unused", 32'h21090001, 32'h12C, 1, 0, 32'h10, 32'h22, 0, 5'd0, 32'h0, 0,
                      mk(7'b1100010, 3'b000, 6'h01, 32'h10, 32'h22, 32'h1, 32'h12C, 5'd8, 5'd9, 5'd9));

        $display("[TB] flush and empty slot");
        applyStimulus("lw3", 32'h8D090000, 32'h130, 1, 0, 32'h10, 32'h22, 0, 5'd0, 32'h0, 0,
                      mk(7'b1110110, 3'b000, 6'h00, 32'h10, 32'h22, 32'h0, 32'h130, 5'd8, 5'd9, 5'd9));
        applyStimulus("sw_flushed", 32'hAD090004, 32'h134, 1, 1, 32'h10, 32'h22, 0, 5'd0, 32'h0, 0, bubble);
        applyStimulus("lw4", 32'h8D090000, 32'h138, 1, 0, 32'h10, 32'h22, 0, 5'd0, 32'h0, 0,
                      mk(7'b1110110, 3'b000, 6'h00, 32'h10, 32'h22, 32'h0, 32'h138, 5'd8, 5'd9, 5'd9));
        applyStimulus("add_invalid", 32'h01285020, 32'h13C, 0, 0, 32'h33, 32'h10, 0, 5'd0, 32'h0, 0, bubble);

        $display("[TB] write-back bypass");
        applyStimulus("wb_bypass", 32'h20A90001, 32'h140, 1, 0, 32'h0, 32'h22, 1, 5'd5, 32'hDEADBEEF, 0,
                      mk(7'b1100010, 3'b000, 6'h01, bypass_exp, 32'h22, 32'h1, 32'h140, 5'd5, 5'd9, 5'd9));
        applyStimulus("wb_r0", 32'h20090001, 32'h144, 1, 0, 32'h0, 32'h22, 1, 5'd0, 32'hDEADBEEF, 0,
                      mk(7'b1100010, 3'b000, 6'h01, 32'h0, 32'h22, 32'h1, 32'h144, 5'd0, 5'd9, 5'd9));

        $display("[TB] reset mid-stream");
        applyStimulus("lw5", 32'h8D090000, 32'h148, 1, 0, 32'h10, 32'h22, 0, 5'd0, 32'h0, 0,
                      mk(7'b1110110, 3'b000, 6'h00, 32'h10, 32'h22, 32'h0, 32'h148, 5'd8, 5'd9, 5'd9));
        @(posedge clk);
        #2;
        i_instruction = 32'h01285020;
        #1;
        checkOutput("stall_before_reset", {191'd0, o_stall}, {191'd0, 1'b1});
        #1;
        reset = 1'b1;
        #1;
        checkOutput("async_reset_out", {33'd0, sample_dut()}, 192'd0);
        checkOutput("async_reset_stall", {191'd0, o_stall}, 192'd0);
        @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        applyStimulus("unsupported", 32'hFC000000, 32'h200, 1, 0, 32'h10, 32'h22, 0, 5'd0, 32'h0, 0, bubble);

        for (int i = 0; i < 20 && exp_q.size() > 0; i++) begin
            @(posedge clk);
            #2;
        end
        checkOutput("scoreboard_drain", {160'd0, 32'(exp_q.size())}, 192'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
